// File: rtl/seq_divider.sv
// Iterative restoring divider with valid/ready handshakes, BITS_PER_CYCLE quotient bits per clock.
// Optional two's-complement mode is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] lop,
    input  logic [WIDTH-1:0] rop,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] mod,
    output logic             div_by_zero
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    if (((WIDTH % BITS_PER_CYCLE) != 0) || (WIDTH < 2)) begin : g_bad_param
        $error("seq_divider: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   dividend_r;   // remaining dividend bits on top, quotient bits enter at bit 0
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   partial_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   mod_r;
    logic               dbz_r;
    logic               last_step_s;
    logic               rop_zero_s;
    logic [WIDTH-1:0]   lop_mag_s;
    logic [WIDTH-1:0]   rop_mag_s;
    logic [WIDTH-1:0]   work_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   mod_fix_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic               neg_quot_r;
    logic               neg_mod_r;
`endif

    assign rop_zero_s  = (rop == {WIDTH{1'b0}});
    assign last_step_s = (cnt_r == CNT_W'(N - 1));

    // Operand magnitudes presented to the unsigned core
    always_comb begin
        lop_mag_s = lop;
        rop_mag_s = rop;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (signed_op && lop[WIDTH-1]) begin
            lop_mag_s = {WIDTH{1'b0}} - lop;
        end else begin
            lop_mag_s = lop;
        end
        if (signed_op && rop[WIDTH-1]) begin
            rop_mag_s = {WIDTH{1'b0}} - rop;
        end else begin
            rop_mag_s = rop;
        end
`endif
    end

    // BITS_PER_CYCLE restoring steps, MSB first, with a WIDTH+1-bit trial subtract
    always_comb begin
        work_s  = dividend_r;
        rem_s   = partial_r;
        trial_s = {(WIDTH + 1){1'b0}};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial_s = {rem_s, work_s[WIDTH-1]};
            work_s  = {work_s[WIDTH-2:0], 1'b0};
            if (trial_s >= {1'b0, divisor_r}) begin
                trial_s   = trial_s - {1'b0, divisor_r};
                work_s[0] = 1'b1;
            end else begin
                work_s[0] = 1'b0;
            end
            rem_s = trial_s[WIDTH-1:0];
        end
    end

    // Sign fix-up applied as the final step retires
    always_comb begin
        quot_fix_s = work_s;
        mod_fix_s  = rem_s;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (neg_quot_r) begin
            quot_fix_s = {WIDTH{1'b0}} - work_s;
        end else begin
            quot_fix_s = work_s;
        end
        if (neg_mod_r) begin
            mod_fix_s = {WIDTH{1'b0}} - rem_s;
        end else begin
            mod_fix_s = rem_s;
        end
`endif
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (rop_zero_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_step_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with registered handshake flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dividend_r <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            partial_r  <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            quot_r     <= {WIDTH{1'b0}};
            mod_r      <= {WIDTH{1'b0}};
            dbz_r      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quot_r <= 1'b0;
            neg_mod_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (rop_zero_s) begin
                            quot_r <= {WIDTH{1'b1}};
                            mod_r  <= lop;
                            dbz_r  <= 1'b1;
                        end else begin
                            dividend_r <= lop_mag_s;
                            divisor_r  <= rop_mag_s;
                            partial_r  <= {WIDTH{1'b0}};
                            cnt_r      <= {CNT_W{1'b0}};
                            dbz_r      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_quot_r <= signed_op && (lop[WIDTH-1] ^ rop[WIDTH-1]);
                            neg_mod_r  <= signed_op && lop[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    dividend_r <= work_s;
                    partial_r  <= rem_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        quot_r <= quot_fix_s;
                        mod_r  <= mod_fix_s;
                    end
                end
                DONE: begin
                    quot_r <= quot_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quot        = quot_r;
    assign mod         = mod_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (WIDTH=16, BITS_PER_CYCLE=1).
// Signed vectors are added when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

    typedef struct {
        logic [15:0] lop;
        logic [15:0] rop;
        logic        sgn;
        logic [15:0] q;
        logic [15:0] m;
        logic        dbz;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] lop;
    logic [15:0] rop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic [15:0] mod;
    logic        div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic        signed_op;
`endif

    int checks;
    int failures;
    vec_t vecs[$];

    seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lop         (lop),
        .rop         (rop),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .mod         (mod),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic s,
                                input logic [15:0] q, input logic [15:0] m, input logic z,
                                input int lat);
        vec_t v;
        v.lop = a; v.rop = b; v.sgn = s; v.q = q; v.m = m; v.dbz = z; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        lop      = a;
        rop      = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = s;
`else
        if (s) $display("note: signed vector requested in unsigned build");
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // lat = number of edges after the accept edge before out_valid is seen
    task automatic wait_done(output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        while (!got && (lat <= 64)) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else lat++;
        end
        chk("done_within_budget", 32'(got), 32'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_retire", 32'(in_ready), 32'd1);
        chk("out_valid_after_retire", 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.lop, v.rop, v.sgn);
        wait_done(lat);
        chk($sformatf("quot %0h/%0h", v.lop, v.rop), 32'(quot), 32'(v.q));
        chk($sformatf("mod %0h/%0h", v.lop, v.rop), 32'(mod), 32'(v.m));
        chk($sformatf("dbz %0h/%0h", v.lop, v.rop), 32'(div_by_zero), 32'(v.dbz));
        chk($sformatf("latency %0h/%0h", v.lop, v.rop), 32'(lat), 32'(v.lat));
        retire();
    endtask

    initial begin
        int lat;
        int seen;
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lop       = 16'd0;
        rop       = 16'd0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = 1'b0;
`endif

        vecs.push_back(mk(16'd100,   16'd7,      1'b0, 16'd14,     16'd2,      1'b0, 16));
        vecs.push_back(mk(16'hFFFF,  16'd1,      1'b0, 16'hFFFF,   16'h0000,   1'b0, 16));
        vecs.push_back(mk(16'd5,     16'd9,      1'b0, 16'd0,      16'd5,      1'b0, 16));
        vecs.push_back(mk(16'd1234,  16'd0,      1'b0, 16'hFFFF,   16'd1234,   1'b1, 0));
        vecs.push_back(mk(16'd0,     16'd5,      1'b0, 16'd0,      16'd0,      1'b0, 16));
        vecs.push_back(mk(16'hFFFF,  16'hFFFF,   1'b0, 16'd1,      16'd0,      1'b0, 16));
        vecs.push_back(mk(16'd40000, 16'd300,    1'b0, 16'd133,    16'd100,    1'b0, 16));
        vecs.push_back(mk(16'hFFFF,  16'h8000,   1'b0, 16'd1,      16'h7FFF,   1'b0, 16));
        vecs.push_back(mk(16'd12345, 16'd1,      1'b0, 16'd12345,  16'd0,      1'b0, 16));
        vecs.push_back(mk(16'd0,     16'd0,      1'b0, 16'hFFFF,   16'd0,      1'b1, 0));
        vecs.push_back(mk(16'd1,     16'hFFFF,   1'b0, 16'd0,      16'd1,      1'b0, 16));
        vecs.push_back(mk(16'hFFF9,  16'd2,      1'b0, 16'h7FFC,   16'd1,      1'b0, 16));
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back(mk(16'hFFF9,  16'd2,      1'b1, 16'hFFFD,   16'hFFFF,   1'b0, 16));
        vecs.push_back(mk(16'h8000,  16'hFFFF,   1'b1, 16'h8000,   16'h0000,   1'b0, 16));
        vecs.push_back(mk(16'd7,     16'hFFFE,   1'b1, 16'hFFFD,   16'd1,      1'b0, 16));
        vecs.push_back(mk(16'hFFF9,  16'hFFFE,   1'b1, 16'd3,      16'hFFFF,   1'b0, 16));
        vecs.push_back(mk(16'h8000,  16'd0,      1'b1, 16'hFFFF,   16'h8000,   1'b1, 0));
`endif

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_mod", 32'(mod), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: hold result 5 cycles while a new request is offered
        start_op(16'd100, 16'd7, 1'b0);
        wait_done(lat);
        chk("hold_latency", 32'(lat), 32'd16);
        lop      = 16'd50;
        rop      = 16'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_quot", 32'(quot), 32'd14);
            chk("hold_mod", 32'(mod), 32'd2);
            chk("hold_dbz", 32'(div_by_zero), 32'd0);
        end
        in_valid = 1'b0;
        retire();

        // out_ready already high: result retires on the first DONE edge
        out_ready = 1'b1;
        start_op(16'd1000, 16'd10, 1'b0);
        wait_done(lat);
        chk("early_ready_quot", 32'(quot), 32'd100);
        chk("early_ready_lat", 32'(lat), 32'd16);
        @(negedge clk);
        chk("early_ready_out_valid", 32'(out_valid), 32'd0);
        chk("early_ready_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Reset mid-CALC discards the in-flight result
        start_op(16'd100, 16'd7, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quot", 32'(quot), 32'd0);
        chk("midrst_mod", 32'(mod), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_stale_result", 32'(seen), 32'd0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
